sync_edge_detect: RTL and testbench

- Multi-channel, single-clock input conditioner for asynchronous or foreign-domain signals.
- Per channel:
  - STAGES-deep metastability synchronizer.
  - Optional debounce filter.
  - Registered previous-value tracking.
  - Rise, fall and any-edge single-cycle pulses, plus a software-clearable sticky rise flag.
- Generalises the toggle-to-pulse receiver: any-edge output with STAGES=2, DEBOUNCE_CYCLES=0 equals the classic ff2^ff3 pulse recovery.
- Sits at the boundary of every clock domain that ingests external levels, toggles or buttons.

---
 rtl/sync_pkg.sv | 18 +
 rtl/sync_edge_chan.sv | 95 +++++++++
 rtl/sync_edge_detect.sv | 54 +++++
 tb/tb_sync_edge_detect.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_pkg.sv
// Shared constants and helpers for the multi-channel synchronizer / edge detector.
package sync_pkg;

    localparam int MIN_STAGES   = 2;
    localparam int MAX_STAGES   = 4;
    localparam int MAX_DEBOUNCE = 65535;

    // Debounce counter width; never collapses to zero bits.
    function automatic int cnt_width(input int d);
        int w;
        w = $clog2(d + 1);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/sync_edge_chan.sv
// One channel: synchronizer chain, optional debounce filter, previous-value
// tracking, edge pulses and a sticky rise flag.
module sync_edge_chan
    import sync_pkg::*;
#(
    parameter int   STAGES          = 2,
    parameter int   DEBOUNCE_CYCLES = 0,
    parameter logic RESET_BIT       = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    input  logic i_clr,
    output logic o_level,
    output logic o_rise,
    output logic o_fall,
    output logic o_edge_p,
    output logic o_sticky_rise
);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] r_sync_ff;

    logic w_sync;
    logic w_stable;
    logic w_rise;
    logic w_fall;
    logic r_prev;
    logic r_sticky;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync_ff <= {STAGES{RESET_BIT}};
        end else begin
            r_sync_ff <= {r_sync_ff[STAGES-2:0], i_d};
        end
    end

    assign w_sync = r_sync_ff[STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_no_debounce
            assign w_stable = w_sync;
        end else begin : g_debounce
            localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

            logic [CNT_W-1:0] r_cnt;
            logic             r_stable;

            // A new value is accepted only after it has been seen on
            // DEBOUNCE_CYCLES consecutive edges; any return to the stable
            // value restarts the count.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt    <= '0;
                    r_stable <= RESET_BIT;
                end else if (w_sync == r_stable) begin
                    r_cnt <= '0;
                end else if (r_cnt == CNT_LAST) begin
                    r_stable <= w_sync;
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign w_stable = r_stable;
        end
    endgenerate

    assign w_rise = w_stable & ~r_prev;
    assign w_fall = ~w_stable & r_prev;

    // Set has priority over clear so a rise coinciding with clr is not lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev   <= RESET_BIT;
            r_sticky <= 1'b0;
        end else begin
            r_prev <= w_stable;
            if (w_rise) begin
                r_sticky <= 1'b1;
            end else if (i_clr) begin
                r_sticky <= 1'b0;
            end
        end
    end

    assign o_level       = w_stable;
    assign o_rise        = w_rise;
    assign o_fall        = w_fall;
    assign o_edge_p      = w_stable ^ r_prev;
    assign o_sticky_rise = r_sticky;

endmodule

// File: rtl/sync_edge_detect.sv
// Multi-channel input conditioner: WIDTH independent sync_edge_chan instances
// plus elaboration-time parameter range checks.
module sync_edge_detect
    import sync_pkg::*;
#(
    parameter int               WIDTH           = 1,
    parameter int               STAGES          = 2,
    parameter int               DEBOUNCE_CYCLES = 0,
    parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] clr,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] edge_p,
    output logic [WIDTH-1:0] sticky_rise
);

    generate
        if (WIDTH < 1) begin : g_bad_width
            $error("sync_edge_detect: WIDTH must be at least 1");
        end
        if (STAGES < MIN_STAGES || STAGES > MAX_STAGES) begin : g_bad_stages
            $error("sync_edge_detect: STAGES must be in 2..4");
        end
        if (DEBOUNCE_CYCLES < 0 || DEBOUNCE_CYCLES > MAX_DEBOUNCE) begin : g_bad_debounce
            $error("sync_edge_detect: DEBOUNCE_CYCLES must be in 0..65535");
        end
    endgenerate

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_chan
            sync_edge_chan #(
                .STAGES          (STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .RESET_BIT       (RESET_VAL[i])
            ) u_chan (
                .clk           (clk),
                .rst           (rst),
                .i_d           (d[i]),
                .i_clr         (clr[i]),
                .o_level       (level[i]),
                .o_rise        (rise[i]),
                .o_fall        (fall[i]),
                .o_edge_p      (edge_p[i]),
                .o_sticky_rise (sticky_rise[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_sync_edge_detect.sv
// Directed bench: pulse events go through an expected queue checked by a
// negedge monitor; levels and sticky flags are checked inline.
module tb_sync_edge_detect;

    localparam int EW = 23;  // {dut, ch, rise, fall, edge_p, cycle[15:0]}

    logic clk;
    logic rst;
    logic rst_d;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic [EW-1:0] exp_q[$];

    // dut_a: WIDTH=4, STAGES=2, D=0, RESET_VAL=0101
    logic [3:0] d_a, clr_a, level_a, rise_a, fall_a, edge_a, sticky_a;
    // dut_b: WIDTH=1, STAGES=3, D=0
    logic [0:0] d_b, clr_b, level_b, rise_b, fall_b, edge_b, sticky_b;
    // dut_c: WIDTH=2, STAGES=2, D=4
    logic [1:0] d_c, clr_c, level_c, rise_c, fall_c, edge_c, sticky_c;
    // dut_d: WIDTH=1, STAGES=3, D=8, separate reset
    logic [0:0] d_d, clr_d, level_d, rise_d, fall_d, edge_d, sticky_d;

    sync_edge_detect #(.WIDTH(4), .STAGES(2), .DEBOUNCE_CYCLES(0), .RESET_VAL(4'b0101)) dut_a (
        .clk(clk), .rst(rst), .d(d_a), .clr(clr_a), .level(level_a), .rise(rise_a),
        .fall(fall_a), .edge_p(edge_a), .sticky_rise(sticky_a));

    sync_edge_detect #(.WIDTH(1), .STAGES(3), .DEBOUNCE_CYCLES(0), .RESET_VAL(1'b0)) dut_b (
        .clk(clk), .rst(rst), .d(d_b), .clr(clr_b), .level(level_b), .rise(rise_b),
        .fall(fall_b), .edge_p(edge_b), .sticky_rise(sticky_b));

    sync_edge_detect #(.WIDTH(2), .STAGES(2), .DEBOUNCE_CYCLES(4), .RESET_VAL(2'b00)) dut_c (
        .clk(clk), .rst(rst), .d(d_c), .clr(clr_c), .level(level_c), .rise(rise_c),
        .fall(fall_c), .edge_p(edge_c), .sticky_rise(sticky_c));

    sync_edge_detect #(.WIDTH(1), .STAGES(3), .DEBOUNCE_CYCLES(8), .RESET_VAL(1'b0)) dut_d (
        .clk(clk), .rst(rst_d), .d(d_d), .clr(clr_d), .level(level_d), .rise(rise_d),
        .fall(fall_d), .edge_p(edge_d), .sticky_rise(sticky_d));

    // ---------------- clock / cycle counter ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_exp(input logic [1:0] id, input logic [1:0] ch,
                            input logic r, input logic f, input int c);
        logic [15:0] c16;
        c16 = c[15:0];
        exp_q.push_back({id, ch, r, f, 1'b1, c16});
    endtask

    // ---------------- monitor / scoreboard ----------------
    task automatic scan(input logic [1:0] id, input logic [3:0] r, input logic [3:0] f,
                        input logic [3:0] e);
        logic [EW-1:0] got;
        logic [EW-1:0] req;
        logic [15:0]   c16;
        for (int ch = 0; ch < 4; ch++) begin
            if (e[ch] === 1'b1 || r[ch] === 1'b1 || f[ch] === 1'b1) begin
                c16 = cyc[15:0];
                got = {id, 2'(ch), r[ch], f[ch], e[ch], c16};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL pulse_unexpected: actual %h required none", got);
                end else begin
                    req = exp_q.pop_front();
                    if (got !== req) begin
                        errors++;
                        $display("FAIL pulse_event: actual %h required %h", got, req);
                    end
                end
            end
        end
    endtask

    always @(negedge clk) begin
        scan(2'd0, rise_a, fall_a, edge_a);
        scan(2'd1, {3'b0, rise_b}, {3'b0, fall_b}, {3'b0, edge_b});
        scan(2'd2, {2'b0, rise_c}, {2'b0, fall_c}, {2'b0, edge_c});
        scan(2'd3, {3'b0, rise_d}, {3'b0, fall_d}, {3'b0, edge_d});
    end

    // ---------------- stimulus ----------------
    initial begin
        int c;
        rst   = 1'b1;
        rst_d = 1'b1;
        d_a   = 4'b0101;
        clr_a = 4'b0;
        d_b   = 1'b0;
        clr_b = 1'b0;
        d_c   = 2'b0;
        clr_c = 2'b0;
        d_d   = 1'b0;
        clr_d = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_level_a", 32'(level_a), 32'h5);
        check("reset_sticky_a", 32'(sticky_a), 32'h0);
        check("reset_pulses_a", 32'({rise_a, fall_a, edge_a}), 32'h0);
        check("reset_level_d", 32'(level_d), 32'h0);
        rst   = 1'b0;
        rst_d = 1'b0;

        // idle after reset with d == RESET_VAL: no edges
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("idle_level_a", 32'(level_a), 32'h5);
            check("idle_pulses_a", 32'({rise_a, fall_a, edge_a}), 32'h0);
        end

        // latency, STAGES=2, D=0 (channel 1 of dut_a)
        c = cyc;
        d_a[1] = 1'b1;
        push_exp(2'd0, 2'd1, 1'b1, 1'b0, c + 2);
        @(negedge clk);
        check("lat2_level_before", 32'(level_a[1]), 32'h0);
        @(negedge clk);
        check("lat2_level_after", 32'(level_a[1]), 32'h1);
        repeat (3) @(negedge clk);
        check("lat2_sticky", 32'(sticky_a[1]), 32'h1);
        c = cyc;
        d_a[1] = 1'b0;
        push_exp(2'd0, 2'd1, 1'b0, 1'b1, c + 2);
        repeat (5) @(negedge clk);
        check("lat2_sticky_held", 32'(sticky_a[1]), 32'h1);

        // latency, STAGES=3, D=0
        c = cyc;
        d_b = 1'b1;
        push_exp(2'd1, 2'd0, 1'b1, 1'b0, c + 3);
        repeat (2) @(negedge clk);
        check("lat3_level_before", 32'(level_b), 32'h0);
        @(negedge clk);
        check("lat3_level_after", 32'(level_b), 32'h1);
        repeat (3) @(negedge clk);
        c = cyc;
        d_b = 1'b0;
        push_exp(2'd1, 2'd0, 1'b0, 1'b1, c + 3);
        repeat (6) @(negedge clk);

        // debounce D=4: 3-cycle pulse rejected
        d_c[1] = 1'b1;
        repeat (3) @(negedge clk);
        d_c[1] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("db_reject_level", 32'(level_c[1]), 32'h0);
        end
        // 4+ cycles accepted after STAGES+D
        c = cyc;
        d_c[1] = 1'b1;
        push_exp(2'd2, 2'd1, 1'b1, 1'b0, c + 6);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("db_accept_wait", 32'(level_c[1]), 32'h0);
        end
        @(negedge clk);
        check("db_accept_level", 32'(level_c[1]), 32'h1);
        repeat (4) @(negedge clk);
        // falling with a one-cycle glitch back high that restarts the count
        d_c[1] = 1'b0;
        repeat (2) @(negedge clk);
        d_c[1] = 1'b1;
        @(negedge clk);
        c = cyc;
        d_c[1] = 1'b0;
        push_exp(2'd2, 2'd1, 1'b0, 1'b1, c + 6);
        repeat (5) @(negedge clk);
        check("db_glitch_hold", 32'(level_c[1]), 32'h1);
        repeat (5) @(negedge clk);
        check("db_glitch_level", 32'(level_c[1]), 32'h0);

        // sticky collision on channel 3 of dut_a
        check("sticky3_initial", 32'(sticky_a[3]), 32'h0);
        c = cyc;
        d_a[3] = 1'b1;
        push_exp(2'd0, 2'd3, 1'b1, 1'b0, c + 2);
        repeat (2) @(negedge clk);
        clr_a[3] = 1'b1;
        @(negedge clk);
        clr_a[3] = 1'b0;
        check("sticky3_collision", 32'(sticky_a[3]), 32'h1);
        repeat (2) @(negedge clk);
        check("sticky3_held", 32'(sticky_a[3]), 32'h1);
        clr_a[3] = 1'b1;
        @(negedge clk);
        clr_a[3] = 1'b0;
        check("sticky3_cleared", 32'(sticky_a[3]), 32'h0);
        c = cyc;
        d_a[3] = 1'b0;
        push_exp(2'd0, 2'd3, 1'b0, 1'b1, c + 2);
        repeat (4) @(negedge clk);
        check("sticky3_no_set_on_fall", 32'(sticky_a[3]), 32'h0);

        // toggle recovery on channel 2 (starts at 1): 10 toggles, 3 cycles apart
        for (int k = 0; k < 10; k++) begin
            c = cyc;
            d_a[2] = ~d_a[2];
            push_exp(2'd0, 2'd2, d_a[2], ~d_a[2], c + 2);
            repeat (3) @(negedge clk);
        end
        repeat (2) @(negedge clk);
        check("toggle_level", 32'(level_a[2]), 32'h1);
        check("toggle_sticky", 32'(sticky_a[2]), 32'h1);

        // async reset mid-debounce, STAGES=3, D=8
        c = cyc;
        d_d = 1'b1;
        push_exp(2'd3, 2'd0, 1'b1, 1'b0, c + 11);
        repeat (14) @(negedge clk);
        check("rst_pre_level", 32'(level_d), 32'h1);
        check("rst_pre_sticky", 32'(sticky_d), 32'h1);
        d_d = 1'b0;
        repeat (8) @(negedge clk);
        #2 rst_d = 1'b1;
        #1;
        check("rst_async_level", 32'(level_d), 32'h0);
        check("rst_async_sticky", 32'(sticky_d), 32'h0);
        check("rst_async_pulses", 32'({rise_d, fall_d, edge_d}), 32'h0);
        d_d = 1'b1;
        repeat (2) @(negedge clk);
        rst_d = 1'b0;
        c = cyc;
        push_exp(2'd3, 2'd0, 1'b1, 1'b0, c + 11);
        repeat (10) @(negedge clk);
        check("rst_release_wait", 32'(level_d), 32'h0);
        repeat (4) @(negedge clk);
        check("rst_release_level", 32'(level_d), 32'h1);

        repeat (5) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pulse_missing: actual %0d pending required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
